vga_sprite_renderer: RTL and testbench
======================================

Name: vga_sprite_renderer

Overview:
- Pixel-colour stage directly downstream of vga_sync_module_800_600_60. It sits beside the 64x64x1 sprite ROM (rom_ip: 6-bit address, 64-bit row data, 1-cycle read latency).
- Takes the active-area pixel coordinates and Ready_Sig, fetches sprite rows from the ROM, and produces RGB565.
- Moves the sprite one STEP per frame, bouncing off the screen edges.

Parameters:
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 600, active lines per frame
- STEP, 1, pixels moved per axis per frame; legal range 1..32
- FG_COLOR, 16'hFFFF, RGB565 colour for ROM bit = 1
- BG_COLOR, 16'h001F, RGB565 colour for active pixels outside the sprite or ROM bit = 0

Ports:
- vga_clk  input  1  pixel clock (40 MHz from PLL)
- rst_n  input  1  asynchronous active-low reset
- Ready_Sig  input  1  high while the coordinates are inside the active area
- Column_Addr_Sig  input  12  active x coordinate, 0..H_ACTIVE-1
- Row_Addr_Sig  input  12  active y coordinate, 0..V_ACTIVE-1
- rom_addr  output  6  sprite row address to the ROM
- rom_data  input  64  sprite row data; bit 63 = leftmost pixel; valid 1 cycle after rom_addr
- Red_Sig  output  5  red
- Green_Sig  output  6  green
- Blue_Sig  output  5  blue

Behaviour:
- Reset (asynchronous, active-low):
  - sprite_x = 0, sprite_y = 0, dir_x = +, dir_y = +.
  - Pipeline valid/hit flags cleared; Red/Green/Blue = 0.
  - rom_addr shows 0 while in reset (combinational from the reset coordinate registers).
- Stage 0 (combinational):
  - dx = col - sprite_x, dy = row - sprite_y (12-bit unsigned).
  - hit0 = Ready_Sig && col >= sprite_x && col < sprite_x+64 && row >= sprite_y && row < sprite_y+64.
  - rom_addr = dy[5:0]. Driven every cycle; value is don't-care when hit0 = 0.
- Stage 1 (register): act1 <= Ready_Sig; hit1 <= hit0; bit1 <= dx[5:0].
- Stage 2 (register):
  - act1 = 0 -> RGB <= 0.
  - act1 = 1, hit1 = 0 -> RGB <= BG_COLOR.
  - act1 = 1, hit1 = 1 -> RGB <= rom_data[63-bit1] ? FG_COLOR : BG_COLOR.
- Latency:
  - RGB corresponds to the coordinates presented 2 vga_clk cycles earlier.
  - The top level delays HSYNC/VSYNC by 2 to match; that delay is outside this block.
- Frame tick:
  - tick = Ready_Sig && col == H_ACTIVE-1 && row == V_ACTIVE-1 (last active pixel).
  - Position updates only on tick, so it is constant across the whole visible frame.
  - The pixel in flight at tick already has hit/bit registered; it is unaffected.
- Motion, per axis (x shown; y identical with V_ACTIVE), LIM = H_ACTIVE-64:
  - dir +: if x+STEP >= LIM -> x <= LIM, dir <= -; else x <= x+STEP.
  - dir -: if x <= STEP -> x <= 0, dir <= +; else x <= x-STEP.
  - Both axes reverse independently on the same tick (corner hit).
- Boundaries:
  - Coordinates outside the active range with Ready_Sig = 1 are not expected; they are treated as a miss.
  - Sprite never leaves the screen, so there is no wrap-around.
- Reset mid-frame: everything returns to reset values on the asserting edge. After release, rendering resumes on the next cycle with the sprite at (0,0).

Optional Feature:
- Macro: SPRITE_SCALE2X_EN.
- Defined: sprite drawn 128x128.
  - Bounds use +128; LIM = H_ACTIVE-128 / V_ACTIVE-128.
  - rom_addr = dy[6:1]; bit1 = dx[6:1].
  - Each ROM bit covers 2x2 pixels.
- Undefined: native 64x64 behaviour as above.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults and SPR_SIZE (64).
  - typedef rgb565_t: struct with r[4:0], g[5:0], b[4:0].
  - COLOR_BLACK constant.
- One sub-module: sprite_motion.
  - Inputs: vga_clk, rst_n, tick.
  - Outputs: sprite_x, sprite_y.
  - Contains the bounce registers and direction flags.
- The pixel pipeline stays in vga_sprite_renderer.

Test Plan:
- Reset mid-line with Ready_Sig = 1 -> RGB = 0 within the same cycle; sprite_x = sprite_y = 0; the first pixel after release at (0,0) with ROM row0 bit63 = 1 gives RGB = FFFF two cycles later.
- Frame 0, ROM model returns 64'h8000_0000_0000_0001 for every row:
  - (0,0) -> FFFF; (63,0) -> FFFF; (1,0) -> 001F; (64,0) -> 001F.
  - rom_addr = 5 at row 5.
  - Output 2 cycles after each coordinate.
- Ready_Sig = 0 for a blanking stretch -> RGB = 0 exactly 2 cycles after Ready falls, and back to BG 2 cycles after it rises.
- Run 10 frames with STEP = 1 -> after the 10th tick sprite at (10,10); a pixel at (9,9) is 001F and one at (10,10) follows ROM bit63.
- Run 736 frames with STEP = 1 -> x clamps at 736 and dir_x flips; the next tick gives x = 735. Separately, y hits 536 at frame 536 and reverses.
- With SPRITE_SCALE2X_EN, ROM bit63 = 1 and bit62 = 0 -> (0,0), (1,0), (0,1), (1,1) are FFFF; (2,0) is 001F; rom_addr = 1 at rows 2 and 3.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, pixel type and bounce helper for the VGA sprite renderer.
// SPRITE_SCALE2X_EN doubles the on-screen sprite size (each ROM bit covers 2x2 pixels).
package vga_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;
  localparam int SPR_SIZE     = 64;

`ifdef SPRITE_SCALE2X_EN
  localparam int SPR_SCALE = 2;
`else
  localparam int SPR_SCALE = 1;
`endif

  localparam int SPR_DRAW = SPR_SIZE * SPR_SCALE;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam rgb565_t COLOR_BLACK = '0;

  // Returns {dir_neg, pos} after one frame step; the sprite clamps to the edge and reverses there.
  function automatic logic [12:0] bounce_step(input logic [11:0] pos,
                                              input logic        dir_neg,
                                              input logic [11:0] step,
                                              input logic [11:0] lim);
    logic [12:0] res;
    if (!dir_neg) begin
      if (pos + step >= lim) res = {1'b1, lim};
      else                   res = {1'b0, pos + step};
    end else begin
      if (pos <= step)       res = {1'b0, 12'd0};
      else                   res = {1'b1, pos - step};
    end
    return res;
  endfunction

endpackage

// File: rtl/sprite_motion.sv
// Per-frame sprite position: one STEP per axis on each tick, bouncing off the screen edges.
// Honours SPRITE_SCALE2X_EN through vga_pkg::SPR_DRAW (larger sprite, smaller travel limit).
module sprite_motion
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int STEP     = 1
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        tick,
  output logic [11:0] sprite_x,
  output logic [11:0] sprite_y
);

  localparam logic [11:0] LIM_X  = 12'(H_ACTIVE - SPR_DRAW);
  localparam logic [11:0] LIM_Y  = 12'(V_ACTIVE - SPR_DRAW);
  localparam logic [11:0] STEP_V = 12'(STEP);

  logic [11:0] x_q, y_q;
  logic        dir_x_q, dir_y_q;   // 1 = moving towards 0
  logic [12:0] step_x_d, step_y_d;

  assign step_x_d = bounce_step(x_q, dir_x_q, STEP_V, LIM_X);
  assign step_y_d = bounce_step(y_q, dir_y_q, STEP_V, LIM_Y);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
    end else if (tick) begin
      {dir_x_q, x_q} <= step_x_d;
      {dir_y_q, y_q} <= step_y_d;
    end
  end

  assign sprite_x = x_q;
  assign sprite_y = y_q;

endmodule

// File: rtl/vga_sprite_renderer.sv
// Two-stage pixel pipeline: sprite hit test + ROM fetch, then RGB565 select (2-cycle latency).
// SPRITE_SCALE2X_EN draws the 64x64 ROM image as 128x128 by halving the pixel offsets.
module vga_sprite_renderer
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE = H_ACTIVE_DEF,
  parameter int          V_ACTIVE = V_ACTIVE_DEF,
  parameter int          STEP     = 1,
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h001F
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        Ready_Sig,
  input  logic [11:0] Column_Addr_Sig,
  input  logic [11:0] Row_Addr_Sig,
  output logic [5:0]  rom_addr,
  input  logic [63:0] rom_data,
  output logic [4:0]  Red_Sig,
  output logic [5:0]  Green_Sig,
  output logic [4:0]  Blue_Sig
);

  localparam int          IDX_W = $clog2(SPR_DRAW);
  localparam logic [11:0] DRAW  = 12'(SPR_DRAW);

  logic [11:0]      sprite_x, sprite_y;
  logic [IDX_W-1:0] dx, dy;
  logic [5:0]       bit0;
  logic             hit0, tick;

  logic             act1_q, hit1_q;
  logic [5:0]       bit1_q;
  rgb565_t          rgb_q, rgb_d;

  sprite_motion #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .STEP     (STEP)
  ) u_motion (
    .vga_clk  (vga_clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .sprite_x (sprite_x),
    .sprite_y (sprite_y)
  );

  // Ready_Sig is a plain qualifier, not a handshake: coordinates are consumed every cycle, no back-pressure.
  assign tick = Ready_Sig && (Column_Addr_Sig == 12'(H_ACTIVE - 1))
                          && (Row_Addr_Sig    == 12'(V_ACTIVE - 1));

  assign dx = IDX_W'(Column_Addr_Sig - sprite_x);
  assign dy = IDX_W'(Row_Addr_Sig - sprite_y);

  assign hit0 = Ready_Sig
             && (Column_Addr_Sig >= sprite_x) && (Column_Addr_Sig < sprite_x + DRAW)
             && (Row_Addr_Sig    >= sprite_y) && (Row_Addr_Sig    < sprite_y + DRAW);

`ifdef SPRITE_SCALE2X_EN
  assign rom_addr = 6'(dy >> 1);
  assign bit0     = 6'(dx >> 1);
`else
  assign rom_addr = dy;
  assign bit0     = dx;
`endif

  always_comb begin
    rgb_d = COLOR_BLACK;
    if (act1_q) begin
      rgb_d = rgb565_t'(BG_COLOR);
      if (hit1_q && rom_data[6'd63 - bit1_q]) rgb_d = rgb565_t'(FG_COLOR);
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      act1_q <= 1'b0;
      hit1_q <= 1'b0;
      bit1_q <= '0;
      rgb_q  <= COLOR_BLACK;
    end else begin
      act1_q <= Ready_Sig;
      hit1_q <= hit0;
      bit1_q <= bit0;
      rgb_q  <= rgb_d;
    end
  end

  assign Red_Sig   = rgb_q.r;
  assign Green_Sig = rgb_q.g;
  assign Blue_Sig  = rgb_q.b;

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Self-checking bench for vga_sprite_renderer: randomized pixels against a triangle-wave position model.
module tb_vga_sprite_renderer;

`ifdef SPRITE_SCALE2X_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif
  localparam int H     = 800;
  localparam int V     = 600;
  localparam int S     = 64 * SCALE;
  localparam int LIM_X = H - S;
  localparam int LIM_Y = V - S;
  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h001F;

  logic        clk;
  logic        rst_n;
  logic        ready_sig;
  logic [11:0] col_sig, row_sig;
  logic [5:0]  rom_addr;
  logic [63:0] rom_data;
  logic [4:0]  red, blue;
  logic [5:0]  green;
  logic [15:0] rgb_out;

  logic [63:0] rom_mem [64];
  logic [47:0] exp_q[$];   // {due cycle, expected rgb}
  int          cyc;
  int          ticks;
  int          n_checks;
  int          n_fail;

  vga_sprite_renderer dut (
    .vga_clk         (clk),
    .rst_n           (rst_n),
    .Ready_Sig       (ready_sig),
    .Column_Addr_Sig (col_sig),
    .Row_Addr_Sig    (row_sig),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .Red_Sig         (red),
    .Green_Sig       (green),
    .Blue_Sig        (blue)
  );

  assign rgb_out = {red, green, blue};

  // clock / reset / ROM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached, got=running required=finished");
    $fatal(1, "watchdog");
  end

  // reference model: with STEP = 1 the position is a triangle wave of period 2*LIM
  function automatic int tri_pos(input int n, input int lim);
    int p;
    p = n % (2 * lim);
    return (p <= lim) ? p : (2 * lim - p);
  endfunction

  function automatic logic [15:0] model_rgb(input bit ready, input int col, input int row);
    int sx, sy, r, b;
    if (!ready) return 16'h0000;
    sx = tri_pos(ticks, LIM_X);
    sy = tri_pos(ticks, LIM_Y);
    if (col >= sx && col < sx + S && row >= sy && row < sy + S) begin
      r = (row - sy) / SCALE;
      b = (col - sx) / SCALE;
      return rom_mem[r][63 - b] ? FG : BG;
    end
    return BG;
  endfunction

  // scoreboard: each expectation falls due two clocks after its coordinate was presented
  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0][47:16]) <= cyc) begin
      logic [47:0] e;
      e = exp_q.pop_front();
      n_checks = n_checks + 1;
      if (rgb_out !== e[15:0]) begin
        n_fail = n_fail + 1;
        $display("FAIL pixel_rgb cyc=%0d got=%h required=%h", cyc, rgb_out, e[15:0]);
      end
    end
  end

  // driver tasks
  task automatic present(input bit ready, input int col, input int row);
    ready_sig = ready;
    col_sig   = 12'(col);
    row_sig   = 12'(row);
    exp_q.push_back({32'(cyc + 2), model_rgb(ready, col, row)});
    if (ready && col == H - 1 && row == V - 1) ticks = ticks + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    present(1'b0, 0, 0);
    present(1'b0, 0, 0);
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    n_checks = n_checks + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic randomize_rom();
    for (int i = 0; i < 64; i++) rom_mem[i] = {$urandom(), $urandom()};
  endtask

  task automatic check_rom_addr(input string name, input int col, input int row);
    int sy;
    ready_sig = 1'b1;
    col_sig   = 12'(col);
    row_sig   = 12'(row);
    #1;
    sy = tri_pos(ticks, LIM_Y);
    n_checks = n_checks + 1;
    if (rom_addr !== 6'((row - sy) / SCALE)) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%0d required=%0d", name, rom_addr, 6'((row - sy) / SCALE));
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    ready_sig = 1'b1;
    col_sig = 12'd100;
    row_sig = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks = n_checks + 2;
    if (rgb_out !== 16'h0000) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_rgb got=%h required=0000", rgb_out);
    end
    if (rom_addr !== 6'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_rom_addr got=%0d required=0", rom_addr);
    end
    ticks = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_frame0();
    int cols [9] = '{0, 63, 1, 64, 0, 1, 2, 0, 0};
    int rows [9] = '{0, 0,  0, 0,  1, 1, 0, 5, 3};
    for (int i = 0; i < 64; i++) rom_mem[i] = 64'h8000_0000_0000_0001;
    drain();
    check_rom_addr("rom_addr_row5", 0, 5);
    check_rom_addr("rom_addr_row2", 0, 2);
    check_rom_addr("rom_addr_row3", 0, 3);
    for (int i = 0; i < 9; i++) present(1'b1, cols[i], rows[i]);
    drain();
  endtask

  task automatic test_blanking();
    for (int i = 0; i < 4; i++) present(1'b1, $urandom_range(300, 700), $urandom_range(300, 400));
    for (int i = 0; i < 6; i++) present(1'b0, $urandom_range(0, 799), $urandom_range(0, 599));
    for (int i = 0; i < 4; i++) present(1'b1, $urandom_range(300, 700), $urandom_range(300, 400));
    drain();
  endtask

  task automatic test_motion();
    randomize_rom();
    rom_mem[0][63] = 1'b1;
    for (int i = 0; i < 10; i++) present(1'b1, H - 1, V - 1);
    check_rom_addr("rom_addr_moved", 10, 14);
    present(1'b1, 9, 9);
    present(1'b1, 10, 10);
    present(1'b1, 10 + S - 1, 10);
    present(1'b1, 10 + S, 10);
    present(1'b1, 10, 10 + S - 1);
    present(1'b1, 10, 10 + S);
    drain();
  endtask

  task automatic test_bounce();
    int sx, sy, c, r;
    for (int t = 0; t < 1100; t++) begin
      present(1'b1, H - 1, V - 1);
      sx = tri_pos(ticks, LIM_X);
      sy = tri_pos(ticks, LIM_Y);
      for (int k = 0; k < 3; k++) begin
        c = sx - 2 + $urandom_range(0, S + 3);
        r = sy - 2 + $urandom_range(0, S + 3);
        c = (c < 0) ? 0 : (c > H - 1) ? H - 1 : c;
        r = (r < 0) ? 0 : (r > V - 2) ? V - 2 : r;
        present(1'b1, c, r);
      end
      present(1'b1, sx, sy);
      if (sx > 0) present(1'b1, sx - 1, sy);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) present(1'b1, $urandom_range(0, 799), $urandom_range(0, 598));
    ready_sig = 1'b1;
    col_sig = 12'd400;
    row_sig = 12'd300;
    rst_n = 1'b0;
    #1;
    n_checks = n_checks + 1;
    if (rgb_out !== 16'h0000) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_mid_rgb got=%h required=0000", rgb_out);
    end
    exp_q.delete();
    ticks = 0;
    rom_mem[0][63] = 1'b1;
    @(posedge clk);
    #1;
    n_checks = n_checks + 1;
    if (rgb_out !== 16'h0000) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_mid_hold got=%h required=0000", rgb_out);
    end
    rst_n = 1'b1;
    present(1'b1, 0, 0);
    present(1'b1, 0, 1);
    present(1'b1, 64 * SCALE, 0);
    drain();
  endtask

  task automatic test_random();
    int c, r;
    bit rdy;
    for (int blk = 0; blk < 4; blk++) begin
      randomize_rom();
      for (int i = 0; i < 150; i++) begin
        rdy = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 29) == 0) begin
          present(1'b1, H - 1, V - 1);
        end else begin
          if ($urandom_range(0, 1) == 0) begin
            c = tri_pos(ticks, LIM_X) + $urandom_range(0, S - 1);
            r = tri_pos(ticks, LIM_Y) + $urandom_range(0, S - 1);
            if (c == H - 1 && r == V - 1) r = V - 2;
          end else begin
            c = $urandom_range(0, 799);
            r = $urandom_range(0, 598);
          end
          present(rdy, c, r);
        end
      end
      drain();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    ticks = 0;
    rst_n = 1'b0;
    ready_sig = 1'b0;
    col_sig = '0;
    row_sig = '0;
    for (int i = 0; i < 64; i++) rom_mem[i] = '0;
    test_reset();
    test_frame0();
    test_blanking();
    test_motion();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
